// File: rtl/nbitmux_pkg.sv
// Shared helpers for the registered M:1 operand selector.
package nbitmux_pkg;

  localparam int unsigned MAX_W = 1024;
  localparam logic [MAX_W-1:0] ZERO_WORD = '0;

  // Ceiling log2 for select sizing; clog2(1) is taken as 1 so sel is never zero-width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 1) ? v - 1 : 1;
    for (int i = 0; i < 32; i++) begin
      if (x != 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nbitmux_m.sv
// Combinational M:1, N-bit word selector; flags select values beyond the last input.
module nbitmux_m
  import nbitmux_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic [M*N-1:0]      in_data,
  input  logic [clog2(M)-1:0] sel,
  output logic [N-1:0]        data_c,
  output logic                err_c
);

  localparam int unsigned SELW = clog2(M);

  // Out-of-range selects fall through to the zero word with the error flag set.
  always_comb begin
    data_c = N'(ZERO_WORD);
    err_c  = 1'b1;
    for (int unsigned k = 0; k < M; k++) begin
      if (sel == SELW'(k)) begin
        data_c = in_data[k*N +: N];
        err_c  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nbitmux_pipe.sv
// M-way operand selector with a registered valid/ready output stage backed by a
// one-entry skid register, so in_ready depends only on local state.
module nbitmux_pipe
  import nbitmux_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [M*N-1:0]      in_data,
  input  logic [clog2(M)-1:0] sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [N-1:0]        out_data,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
);

  if (N < 1) begin : g_bad_n
    $error("nbitmux_pipe: N must be at least 1");
  end
  if (M < 2) begin : g_bad_m
    $error("nbitmux_pipe: M must be at least 2");
  end

  logic [N-1:0] sel_data_c;
  logic         sel_err_c;

  logic [N-1:0] skid_data;
  logic         skid_err;
  logic         skid_valid;

  logic [N-1:0] out_data_nxt;
  logic         out_err_nxt;
  logic         out_valid_nxt;
  logic [N-1:0] skid_data_nxt;
  logic         skid_err_nxt;
  logic         skid_valid_nxt;

  logic         accept;
  logic         consume;

  nbitmux_m #(
    .N(N),
    .M(M)
  ) u_mux (
    .in_data(in_data),
    .sel    (sel),
    .data_c (sel_data_c),
    .err_c  (sel_err_c)
  );

  // Skid occupancy alone gates upstream, keeping in_valid/out_ready off this path.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & ~skid_valid & ~flush;
  assign consume  = out_valid & out_ready;

  // Next-state for main and skid entries; flush overrides every other update.
  always_comb begin
    out_data_nxt   = out_data;
    out_err_nxt    = out_err;
    out_valid_nxt  = out_valid;
    skid_data_nxt  = skid_data;
    skid_err_nxt   = skid_err;
    skid_valid_nxt = skid_valid;

    if (flush) begin
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else begin
      if (consume) begin
        if (skid_valid) begin
          out_data_nxt   = skid_data;
          out_err_nxt    = skid_err;
          skid_valid_nxt = 1'b0;
        end else begin
          out_valid_nxt  = 1'b0;
        end
      end
      // accept implies an empty skid, so it never collides with the transfer above.
      if (accept) begin
        if (!out_valid || consume) begin
          out_data_nxt  = sel_data_c;
          out_err_nxt   = sel_err_c;
          out_valid_nxt = 1'b1;
        end else begin
          skid_data_nxt  = sel_data_c;
          skid_err_nxt   = sel_err_c;
          skid_valid_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= N'(ZERO_WORD);
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
      skid_data  <= N'(ZERO_WORD);
      skid_err   <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      out_data   <= out_data_nxt;
      out_err    <= out_err_nxt;
      out_valid  <= out_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_err   <= skid_err_nxt;
      skid_valid <= skid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_nbitmux_pipe.sv
// Directed bench for nbitmux_pipe: scoreboarded M=4 instance plus an M=3 instance for range errors.
module tb_nbitmux_pipe;

  logic         clk;
  logic         rst_n;

  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out_data;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  b_in_data;
  logic [1:0]   b_sel;
  logic         b_in_valid;
  logic         b_in_ready;
  logic         b_flush;
  logic [31:0]  b_out_data;
  logic         b_out_err;
  logic         b_out_valid;
  logic         b_out_ready;

  int n_cmp;
  int n_bad;
  logic [32:0] sb[$];

  nbitmux_pipe #(.N(32), .M(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  nbitmux_pipe #(.N(32), .M(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return 32'h11111111 * 32'(k + 1);
  endfunction

  // Reference selection for the M=4 instance: {err, data}.
  function automatic logic [32:0] model(input logic [1:0] s);
    return {1'b0, word(int'(s))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: mid-cycle view of what the next rising edge will do.
  always @(negedge clk) begin
    logic        rdy_exp;
    logic [32:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      rdy_exp = (sb.size() < 2);
      chk("sb_in_ready", 64'(in_ready), 64'(rdy_exp));
      chk("sb_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (flush) begin
        sb.delete();
      end else begin
        if (sb.size() != 0 && out_ready) begin
          e = sb.pop_front();
          chk("sb_out_data", 64'(out_data), 64'(e[31:0]));
          chk("sb_out_err", 64'(out_err), 64'(e[32]));
        end
        if (in_valid && rdy_exp) sb.push_back(model(sel));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_data = {word(3), word(2), word(1), word(0)};
    sel = 2'd0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    b_in_data = {word(2), word(1), word(0)};
    b_sel = 2'd0;
    b_in_valid = 1'b0;
    b_flush = 1'b0;
    b_out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // Basic: sel=2 with downstream ready
    sel = 2'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk("basic_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("basic_out_data", 64'(out_data), 64'h33333333);
    chk("basic_out_valid", 64'(out_valid), 64'd1);
    chk("basic_out_err", 64'(out_err), 64'd0);
    chk("basic_in_ready2", 64'(in_ready), 64'd1);
    step();
    chk("basic_drained", 64'(out_valid), 64'd0);

    // Streaming, one item per cycle
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      in_valid = 1'b1;
      step();
      chk("stream_data", 64'(out_data), 64'(word(k)));
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", 64'(out_valid), 64'd0);

    // Stall: main then skid fill, third offer refused
    out_ready = 1'b0;
    sel = 2'd0;
    in_valid = 1'b1;
    step();
    chk("stall_main", 64'(out_data), 64'h11111111);
    chk("stall_ready1", 64'(in_ready), 64'd1);
    sel = 2'd1;
    step();
    chk("stall_hold1", 64'(out_data), 64'h11111111);
    chk("stall_ready_low", 64'(in_ready), 64'd0);
    sel = 2'd2;
    step();
    chk("stall_hold2", 64'(out_data), 64'h11111111);
    chk("stall_refused", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("release_skid", 64'(out_data), 64'h22222222);
    chk("release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("release_third", 64'(out_data), 64'h33333333);
    step();
    chk("release_empty", 64'(out_valid), 64'd0);

    // Flush with both entries full, offer and consume in the same cycle
    out_ready = 1'b0;
    sel = 2'd3;
    in_valid = 1'b1;
    step();
    sel = 2'd1;
    step();
    chk("flush_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    sel = 2'd0;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    step();
    chk("flush_nothing", 64'(out_valid), 64'd0);

    // Flush drops an accept that would otherwise have landed in the skid
    out_ready = 1'b0;
    sel = 2'd2;
    in_valid = 1'b1;
    step();
    flush = 1'b1;
    sel = 2'd1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_valid", 64'(out_valid), 64'd0);
    chk("flush2_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("flush2_nothing", 64'(out_valid), 64'd0);

    // Range error on the M=3 instance
    b_sel = 2'd3;
    b_in_valid = 1'b1;
    step();
    chk("range_data", 64'(b_out_data), 64'd0);
    chk("range_err", 64'(b_out_err), 64'd1);
    chk("range_valid", 64'(b_out_valid), 64'd1);
    b_sel = 2'd1;
    step();
    b_in_valid = 1'b0;
    chk("range_ok_err", 64'(b_out_err), 64'd0);
    chk("range_ok_data", 64'(b_out_data), 64'h22222222);
    step();

    // Async reset between edges with the skid full
    out_ready = 1'b0;
    sel = 2'd0;
    in_valid = 1'b1;
    step();
    sel = 2'd1;
    step();
    in_valid = 1'b0;
    chk("areset_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_data", 64'(out_data), 64'd0);
    chk("areset_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("areset_after", 64'(out_valid), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
